// File: rtl/paddle_position.sv
// Paddle vertical position: queues one-cycle up/down requests in a saturating counter and
// applies one STEP per frame_tick, clamped to the playfield.
module paddle_position #(
    parameter int unsigned Y_W      = 10,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned PADDLE_H = 64,
    parameter int unsigned STEP     = 8,
    parameter int unsigned MAX_PEND = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up,
    input  logic           down,
    input  logic           frame_tick,
    input  logic           hold,
    input  logic           recentre,
    output logic [Y_W-1:0] paddle_y,
    output logic           at_top,
    output logic           at_bottom,
    output logic           moved
);

    localparam logic [Y_W:0]   Y_MAX_W  = (Y_W+1)'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W:0]   STEP_W   = (Y_W+1)'(STEP);
    localparam logic [Y_W-1:0] Y_MAX    = Y_MAX_W[Y_W-1:0];
    localparam logic [Y_W-1:0] CENTRE   = Y_MAX_W[Y_W:1];
    localparam logic signed [4:0] P_MAX = 5'(MAX_PEND);
    localparam logic signed [4:0] P_MIN = -P_MAX;

    logic [Y_W-1:0]    r_paddle_y;
    logic signed [3:0] r_pending;
    logic              r_at_top;
    logic              r_at_bottom;
    logic              r_moved;

    logic [Y_W:0]      w_y_ext;
    logic [Y_W:0]      w_y_wide;
    logic [Y_W-1:0]    w_y_next;
    logic signed [4:0] w_p_ext;
    logic signed [4:0] w_p_step;
    logic signed [4:0] w_p_sum;
    logic signed [3:0] w_p_next;
    logic signed [4:0] w_inc;
    logic              w_tick_apply;

    assign w_y_ext      = {1'b0, r_paddle_y};
    assign w_p_ext      = {r_pending[3], r_pending};
    assign w_tick_apply = frame_tick && (r_pending != 4'sd0);

    // Requests pointing into a wall the paddle already touches are dropped, not queued.
    always_comb begin
        w_inc = 5'sd0;
        if (up && !down && (r_paddle_y != '0))
            w_inc = -5'sd1;
        else if (down && !up && (r_paddle_y != Y_MAX))
            w_inc = 5'sd1;
    end

    always_comb begin
        w_y_wide = w_y_ext;
        w_p_step = w_p_ext;
        if (w_tick_apply) begin
            if (r_pending[3]) begin
                w_y_wide = (w_y_ext < STEP_W) ? '0 : w_y_ext - STEP_W;
                w_p_step = (w_y_wide == '0) ? 5'sd0 : w_p_ext + 5'sd1;
            end else begin
                w_y_wide = (w_y_ext > Y_MAX_W - STEP_W) ? Y_MAX_W : w_y_ext + STEP_W;
                w_p_step = (w_y_wide == Y_MAX_W) ? 5'sd0 : w_p_ext - 5'sd1;
            end
        end
        w_p_sum = w_p_step + w_inc;
        if (w_p_sum > P_MAX)
            w_p_sum = P_MAX;
        else if (w_p_sum < P_MIN)
            w_p_sum = P_MIN;

        w_y_next = w_y_wide[Y_W-1:0];
        w_p_next = w_p_sum[3:0];
        if (recentre) begin
            w_y_next = CENTRE;
            w_p_next = 4'sd0;
        end else if (hold) begin
            w_y_next = r_paddle_y;
            w_p_next = 4'sd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paddle_y  <= CENTRE;
            r_pending   <= 4'sd0;
            r_at_top    <= 1'b0;
            r_at_bottom <= 1'b0;
            r_moved     <= 1'b0;
        end else begin
            r_paddle_y  <= w_y_next;
            r_pending   <= w_p_next;
            r_at_top    <= (w_y_next == '0);
            r_at_bottom <= (w_y_next == Y_MAX);
            r_moved     <= (w_y_next != r_paddle_y);
        end
    end

    assign paddle_y  = r_paddle_y;
    assign at_top    = r_at_top;
    assign at_bottom = r_at_bottom;
    assign moved     = r_moved;

endmodule

// File: tb/tb_paddle_position.sv
// Directed bench for paddle_position: hand-computed positions and flags after each stimulus cycle.
module tb_paddle_position;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, frame_tick = 1'b0, hold = 1'b0, recentre = 1'b0;
    logic [9:0] paddle_y;
    logic       at_top, at_bottom, moved;

    int n_tests = 0;
    int n_fail  = 0;
    logic moved_seen;

    paddle_position dut (
        .clk        (clk),
        .rst        (rst),
        .up         (up),
        .down       (down),
        .frame_tick (frame_tick),
        .hold       (hold),
        .recentre   (recentre),
        .paddle_y   (paddle_y),
        .at_top     (at_top),
        .at_bottom  (at_bottom),
        .moved      (moved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns #1 after the sampling edge.
    task automatic cyc(input logic u, input logic d, input logic t, input logic h, input logic r);
        @(negedge clk);
        up = u; down = d; frame_tick = t; hold = h; recentre = r;
        @(posedge clk);
        #1;
        up = 1'b0; down = 1'b0; frame_tick = 1'b0; hold = 1'b0; recentre = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #12 rst = 1'b0;
        #1;
        // 1: reset state and idle ticks
        check("rst_y", paddle_y, 208);
        check("rst_moved", moved, 0);
        check("rst_top", at_top, 0);
        check("rst_bot", at_bottom, 0);
        moved_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            moved_seen |= moved;
        end
        check("idle_y", paddle_y, 208);
        check("idle_moved", moved_seen, 0);

        // 2: two downs, three ticks
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check("dn1_y", paddle_y, 216); check("dn1_mv", moved, 1);
        tick(); check("dn2_y", paddle_y, 224); check("dn2_mv", moved, 1);
        tick(); check("dn3_y", paddle_y, 224); check("dn3_mv", moved, 0);

        // 3: recentre, five ups saturate at three
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rec_y", paddle_y, 208); check("rec_mv", moved, 1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check("up1_y", paddle_y, 200);
        tick(); check("up2_y", paddle_y, 192);
        tick(); check("up3_y", paddle_y, 184);
        tick(); check("up4_y", paddle_y, 184); check("up4_mv", moved, 0);
        tick(); check("up5_y", paddle_y, 184);

        // 4: bottom wall
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check("near_bot_y", paddle_y, 408);
        check("near_bot_flag", at_bottom, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check("bot_y", paddle_y, 416); check("bot_flag", at_bottom, 1);
        tick(); check("bot_clr_y", paddle_y, 416); check("bot_clr_mv", moved, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check("bot_drop_mv", moved, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check("off_bot_y", paddle_y, 408); check("off_bot_flag", at_bottom, 0);

        // 5: cancel, hold, recentre priority
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check("cancel_y", paddle_y, 208); check("cancel_mv", moved, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("hold_y", paddle_y, 208); check("hold_mv", moved, 0);
        tick(); check("hold_pend_y", paddle_y, 208);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check("pre_rec_y", paddle_y, 216);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("rec_pri_y", paddle_y, 208); check("rec_pri_mv", moved, 1);
        tick(); check("rec_pend_y", paddle_y, 208);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rec_same_mv", moved, 0);

        // 6: top wall, then asynchronous reset between edges
        for (int i = 0; i < 26; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check("top_y", paddle_y, 0); check("top_flag", at_top, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check("top_drop_mv", moved, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("arst_y", paddle_y, 208); check("arst_top", at_top, 0);
        #1 rst = 1'b0;
        tick(); check("arst_pend_y", paddle_y, 208); check("arst_pend_mv", moved, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
